// File: rtl/seq_mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// states and the default widths that match the register file.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_AW    = 5;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_mul_div_if.sv
// Request/result bundle between the register-file read side and the
// multiply/divide unit, including the one-cycle register-file write port.
interface seq_mul_div_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned AW    = MDU_AW
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [AW-1:0]    dest;
    logic             busy;
    logic             done;
    logic             We;
    logic [AW-1:0]    Wr;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, dest,
        input  busy, done, We, Wr, D, hi, lo
    );

    modport slave (
        input  start, op, a, b, dest,
        output busy, done, We, Wr, D, hi, lo
    );

endinterface

// File: rtl/seq_mul_div_neg_cond.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for sign-correcting results.
module neg_cond #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);

    assign y = neg ? ((~x) + N'(1)) : x;

endmodule

// File: rtl/seq_mul_div.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step
// per clock over WIDTH cycles, lower result written back via We/Wr/D.
module seq_mul_div
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH,
    parameter int unsigned AW    = MDU_AW
) (
    input  logic          Clk,
    input  logic          Clrn,
    seq_mul_div_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    op_e              op_q, op_d;
    logic [AW-1:0]    dest_q, dest_d;
    logic             sgn_x_q, sgn_x_d;
    logic             sgn_a_q, sgn_a_d;
    logic             bzero_q, bzero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             is_mul_in;
    logic             is_div;

    assign signed_op = bus.op[0];
    assign sa        = signed_op & bus.a[WIDTH-1];
    assign sb        = signed_op & bus.b[WIDTH-1];
    assign is_mul_in = ~bus.op[1];
    assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);

    neg_cond #(.N(WIDTH)) u_abs_a (.x(bus.a), .neg(sa), .y(abs_a));
    neg_cond #(.N(WIDTH)) u_abs_b (.x(bus.b), .neg(sb), .y(abs_b));

    // Multiply step: conditional add into the upper half, then shift right.
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;

    assign addend   = acc_q[0] ? opnd_q : '0;
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, addend};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: shift left, trial-subtract the divisor, keep if non-negative.
    logic [WIDTH:0]   div_up, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [W2-1:0]    div_next;

    assign div_up   = acc_q[W2-1:WIDTH-1];
    assign div_diff = div_up - {1'b0, opnd_q};
    assign div_ge   = (div_up >= {1'b0, opnd_q});
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_up[WIDTH-1:0];
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Low half of the 2W negate equals a W-bit negate of the quotient.
    logic [W2-1:0]    fix_all;
    logic [WIDTH-1:0] fix_rem;
    logic [WIDTH-1:0] res_hi, res_lo;

    neg_cond #(.N(W2))    u_fix_all (.x(acc_q), .neg(sgn_x_q), .y(fix_all));
    neg_cond #(.N(WIDTH)) u_fix_rem (.x(acc_q[W2-1:WIDTH]), .neg(sgn_a_q & is_div), .y(fix_rem));

    assign res_lo = (is_div && bzero_q) ? '1 : fix_all[WIDTH-1:0];
    assign res_hi = is_div ? fix_rem : fix_all[W2-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        dest_d  = dest_q;
        sgn_x_d = sgn_x_q;
        sgn_a_d = sgn_a_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = IDLE;
                end
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    dest_d  = bus.dest;
                    sgn_x_d = sa ^ sb;
                    sgn_a_d = sa;
                    bzero_d = (bus.b == '0);
                    opnd_d  = is_mul_in ? abs_a : abs_b;
                    acc_d   = {{WIDTH{1'b0}}, (is_mul_in ? abs_b : abs_a)};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= OP_MULU;
            dest_q  <= '0;
            sgn_x_q <= 1'b0;
            sgn_a_q <= 1'b0;
            bzero_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            sgn_x_q <= sgn_x_d;
            sgn_a_q <= sgn_a_d;
            bzero_q <= bzero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.We   = done_q & (dest_q != '0);
    assign bus.Wr   = dest_q;
    assign bus.D    = res_lo;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div: vector table plus random vectors
// through a scoreboard, and hand-written multi-cycle corner sequences.
module tb_seq_mul_div;
    import mdu_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic Clk;
    logic Clrn;
    int   checks = 0;
    int   errors = 0;
    int   we_seen = 0;
    vec_t sb_q[$];
    vec_t cur;

    seq_mul_div_if bus ();

    seq_mul_div dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(negedge Clk) if (bus.We === 1'b1) we_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] dest);
        vec_t v;
        logic [63:0] p;
        int signed sa, sb;
        v.op = op; v.a = a; v.b = b; v.dest = dest;
        sa = a; sb = b;
        case (op)
            OP_MULU: p = {32'b0, a} * {32'b0, b};
            OP_MUL:  p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default: p = '0;
        endcase
        if (op[1] == 1'b0) begin
            v.hi = p[63:32]; v.lo = p[31:0];
        end else if (b == 32'h0) begin
            v.lo = 32'hFFFF_FFFF; v.hi = a;
        end else if (op == OP_DIVU) begin
            v.lo = a / b; v.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.lo = 32'h8000_0000; v.hi = 32'h0;
        end else begin
            v.lo = sa / sb; v.hi = sa % sb;
        end
        return v;
    endfunction

    // Drive a request shortly after an edge; returns just after the accept edge.
    task automatic issue(input vec_t v);
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b; bus.dest = v.dest;
        sb_q.push_back(v);
        @(posedge Clk);
        #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        bus.op = 2'($urandom); bus.dest = 5'($urandom);
    endtask

    task automatic wait_done(input int exp_cycles);
        int n = 0;
        logic found = 1'b0;
        while (n < 100 && !found) begin
            @(posedge Clk);
            n++;
            #1;
            found = bus.done;
        end
        chk("done_seen", 32'(found), 32'd1);
        chk("latency", n, exp_cycles);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            cur = sb_q.pop_front();
            chk("D", bus.D, cur.lo);
            chk("We", 32'(bus.We), 32'(cur.dest != 5'd0));
            chk("Wr", 32'(bus.Wr), 32'(cur.dest));
            chk("busy_at_done", 32'(bus.busy), 32'd1);
        end
    endtask

    task automatic check_hilo(input vec_t v);
        chk("hi", bus.hi, v.hi);
        chk("lo", bus.lo, v.lo);
    endtask

    task automatic run_vec(input vec_t v);
        issue(v);
        wait_done(32);
        @(posedge Clk);
        #1;
        check_hilo(cur);
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("done_after", 32'(bus.done), 32'd0);
    endtask

    vec_t tbl[12];
    vec_t v1, v2;
    int   we_before;

    initial begin
        tbl[0]  = '{OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1]  = '{OP_MUL,  32'hFFFF_FFF9, 32'd3,         5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{OP_DIVU, 32'd100,       32'd0,         5'd4, 32'd100,       32'hFFFF_FFFF};
        tbl[4]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0,         32'h8000_0000};
        tbl[5]  = '{OP_MULU, 32'd3,         32'd4,         5'd0, 32'h0,         32'd12};
        tbl[6]  = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd7, 32'd1,         32'hFFFF_FFFD};
        tbl[7]  = '{OP_DIV,  32'hFFFF_FFF8, 32'd0,         5'd9, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        tbl[8]  = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd1, 32'h0,         32'hFFFF_FFFF};
        tbl[9]  = '{OP_MUL,  32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 32'h0};
        tbl[10] = '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0,        32'd1};
        tbl[11] = '{OP_DIVU, 32'd1000,      32'd7,         5'd10, 32'd6,        32'd142};

        Clrn = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.dest = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_We", 32'(bus.We), 32'd0);
        chk("rst_Wr", 32'(bus.Wr), 32'd0);
        chk("rst_D", bus.D, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        Clrn = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            run_vec(model(2'($urandom), ra, rb, 5'($urandom)));
        end

        // start pulsed at edge 10 while busy must be ignored
        issue(model(OP_MULU, 32'd3, 32'd4, 5'd0));
        repeat (9) @(posedge Clk);
        #1;
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd99; bus.b = 32'd5; bus.dest = 5'd12;
        @(posedge Clk);
        #1;
        bus.start = 1'b0;
        chk("busy_ignore", 32'(bus.busy), 32'd1);
        wait_done(22);
        @(posedge Clk);
        #1;
        check_hilo(cur);
        chk("idle_after_ignore", 32'(bus.busy), 32'd0);

        // reset in mid-divide aborts without a write
        issue(model(OP_DIVU, 32'd1000, 32'd7, 5'd9));
        repeat (14) @(posedge Clk);
        @(posedge Clk);
        #1;
        we_before = we_seen;
        Clrn = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        void'(sb_q.pop_back());
        repeat (2) @(posedge Clk);
        #1;
        Clrn = 1'b1;
        repeat (40) @(posedge Clk);
        #1;
        chk("abort_no_we", we_seen, we_before);
        run_vec(model(OP_DIV, 32'hFFFF_FF00, 32'd10, 5'd14));

        // back-to-back: second start accepted on the edge that leaves DONE
        v1 = model(OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20);
        v2 = model(OP_DIV, 32'h8000_0001, 32'd3, 5'd21);
        issue(v1);
        wait_done(32);
        issue(v2);
        check_hilo(v1);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(32);
        @(posedge Clk);
        #1;
        check_hilo(v2);
        chk("b2b_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
